// File: rtl/sr_cmd_seq.sv
// Command FIFO feeding a pulse sequencer that drives the s/r inputs of a downstream SR stage.
// Define SR_CMD_SEQ_CONFIRM_EN to add q_fb confirmation (CHECK state, timeout, sticky err).
`timescale 1ns/1ps
module sr_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int TMO   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    output logic                     cmd_ready,
    input  logic                     q_fb,
    output logic                     s,
    output logic                     r,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [3:0]  HOLD_C = 4'(HOLD);

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_RST = 2'b10,
        OP_TGL = 2'b11
    } op_t;

`ifdef SR_CMD_SEQ_CONFIRM_EN
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    logic       expected;
    logic [7:0] tmo_cnt;
`else
    typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

    state_t       state;
    logic [1:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]   hold_cnt;
    logic         push;
    logic         pop;
    op_t          head_op;

    assign cmd_ready = !rst && (level != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (level != '0);
    assign head_op   = op_t'(mem[rd_ptr]);
    assign busy      = (state != IDLE) || (level != '0);

    // NOTE: the storage array has no reset; only pointers and level need one, and
    // keeping the array reset-free lets it map onto plain register/RAM cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // The command is resolved against q_fb at the pop edge, so TOGGLE and NOP
    // see the stage value from before their own pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= 1'b0;
            hold_cnt <= '0;
`ifdef SR_CMD_SEQ_CONFIRM_EN
            expected <= 1'b0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state    <= DRIVE;
                        hold_cnt <= 4'd1;
                        case (head_op)
                            OP_SET: s <= 1'b1;
                            OP_RST: r <= 1'b1;
                            OP_TGL: begin
                                s <= !q_fb;
                                r <= q_fb;
                            end
                            default: begin
                                s <= 1'b0;
                                r <= 1'b0;
                            end
                        endcase
`ifdef SR_CMD_SEQ_CONFIRM_EN
                        case (head_op)
                            OP_SET:  expected <= 1'b1;
                            OP_RST:  expected <= 1'b0;
                            OP_TGL:  expected <= !q_fb;
                            default: expected <= q_fb;
                        endcase
`endif
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_C) begin
                        s <= 1'b0;
                        r <= 1'b0;
`ifdef SR_CMD_SEQ_CONFIRM_EN
                        state   <= CHECK;
                        tmo_cnt <= '0;
`else
                        state   <= IDLE;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
`ifdef SR_CMD_SEQ_CONFIRM_EN
                CHECK: begin
                    if (q_fb == expected) begin
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SR_CMD_SEQ_CONFIRM_EN
    assign err = 1'b0;
`endif

endmodule
